fixed_to_fp: RTL and testbench

- Converts the sign / 1-bit integer / 23-bit fraction fixed-point format back into an IEEE-754 single-precision word.
- Fills the return path of the fixed-point datapath: it normalises results computed in fixed point so they can be handed back to float consumers.
- Uses a valid/ready handshake on both sides and a fixed-latency, five-step iterative normaliser (shift by 16, 8, 4, 2, 1).
- The conversion is exact: no rounding, no denormals, no overflow is possible.

---
 rtl/fixed_to_fp.sv | 106 ++++++++++
 tb/tb_fixed_to_fp.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_fp.sv
// Converts sign / 1-bit integer / 23-bit fraction fixed point into an IEEE-754 single.
// Normalisation is a fixed five-step shifter (16, 8, 4, 2, 1), so latency never depends on data.
module fixed_to_fp (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        sign_i,
    input  logic        integer_i,
    input  logic [22:0] fractional_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] fp_o
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t      state;
    logic [23:0] m;
    logic [23:0] m_next;
    logic [7:0]  exp_r;
    logic [7:0]  exp_next;
    logic        sign_r;
    logic        zero_r;
    logic [2:0]  step;

    assign ready_o = (state == IDLE) && !rst;

    // One normalisation step: shift left by k only when the top k bits are all clear.
    always_comb begin
        m_next   = m;
        exp_next = exp_r;
        if (!zero_r) begin
            case (step)
                3'd0: if (m[23:8] == 16'd0) begin
                    m_next   = {m[7:0], 16'd0};
                    exp_next = exp_r - 8'd16;
                end
                3'd1: if (m[23:16] == 8'd0) begin
                    m_next   = {m[15:0], 8'd0};
                    exp_next = exp_r - 8'd8;
                end
                3'd2: if (m[23:20] == 4'd0) begin
                    m_next   = {m[19:0], 4'd0};
                    exp_next = exp_r - 8'd4;
                end
                3'd3: if (m[23:22] == 2'd0) begin
                    m_next   = {m[21:0], 2'd0};
                    exp_next = exp_r - 8'd2;
                end
                3'd4: if (!m[23]) begin
                    m_next   = {m[22:0], 1'b0};
                    exp_next = exp_r - 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            fp_o    <= 32'h0;
            m       <= 24'd0;
            exp_r   <= 8'd0;
            sign_r  <= 1'b0;
            zero_r  <= 1'b0;
            step    <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        m      <= {integer_i, fractional_i};
                        exp_r  <= 8'd127;
                        sign_r <= sign_i;
                        zero_r <= ({integer_i, fractional_i} == 24'd0);
                        step   <= 3'd0;
                        state  <= NORM;
                    end
                end
                NORM: begin
                    m     <= m_next;
                    exp_r <= exp_next;
                    // Pack from the final step's result so the output appears on the same edge.
                    if (step == 3'd4) begin
                        state   <= DONE;
                        valid_o <= 1'b1;
                        fp_o    <= zero_r ? {sign_r, 31'd0}
                                          : {sign_r, exp_next, m_next[22:0]};
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_fp.sv
// Self-checking bench for fixed_to_fp: a per-cycle monitor compares against a leading-one
// reference model, while directed vectors pin both the DUT and the model to literal results.
module tb_fixed_to_fp;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic        sign_i;
    logic        integer_i;
    logic [22:0] fractional_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] fp_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fixed_to_fp dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .sign_i       (sign_i),
        .integer_i    (integer_i),
        .fractional_i (fractional_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .fp_o         (fp_o)
    );

    // Reference: locate the leading one, shift it into the hidden-bit position, bias the exponent.
    function automatic logic [31:0] refFp(input logic s, input logic i, input logic [22:0] f);
        logic [23:0] mag;
        logic [23:0] norm;
        logic [7:0]  e;
        int          lead;
        mag = {i, f};
        if (mag == 24'd0) return {s, 31'd0};
        lead = 0;
        for (int b = 0; b < 24; b++) if (mag[b]) lead = b;
        norm = mag << (23 - lead);
        e    = 8'(127 - (23 - lead));
        return {s, e, norm[22:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Transaction-level model: busy from accept until the output handshake, result after 5 edges.
    bit          busy = 1'b0;
    int          edges = 0;
    logic [31:0] expFp = 32'h0;

    always @(negedge clk) begin
        checkOutput("mon_ready_o", {31'd0, ready_o}, {31'd0, (!busy && !rst)});
        checkOutput("mon_valid_o", {31'd0, valid_o}, {31'd0, (busy && edges >= 5)});
        if (busy && edges >= 5) checkOutput("mon_fp_o", fp_o, expFp);
        if (rst) begin
            busy  = 1'b0;
            edges = 0;
        end else if (!busy) begin
            if (valid_i) begin
                busy  = 1'b1;
                edges = 0;
                expFp = refFp(sign_i, integer_i, fractional_i);
            end
        end else if (edges >= 5 && ready_i) begin
            busy = 1'b0;
        end else begin
            edges++;
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic applyStimulus(input logic s, input logic i, input logic [22:0] f);
        int n;
        sign_i       = s;
        integer_i    = i;
        fractional_i = f;
        valid_i      = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            errors++;
            checks++;
            $display("[TB] FAIL accept_timeout: got ready_o=%b, expected 1", ready_o);
        end
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    // Counts edges after the accept edge until valid_o is seen, bounded.
    task automatic waitResult(output logic [31:0] fp, output int lat);
        lat = 0;
        @(negedge clk);
        while (!valid_o && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        fp = fp_o;
    endtask

    task automatic runVector(input string name, input logic s, input logic i,
                             input logic [22:0] f, input logic [31:0] lit);
        logic [31:0] fp;
        int          lat;
        checkOutput({name, "_model"}, refFp(s, i, f), lit);
        applyStimulus(s, i, f);
        waitResult(fp, lat);
        checkOutput({name, "_latency"}, lat, 32'd5);
        checkOutput(name, fp, lit);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] fp;
        logic [31:0] held;
        int          lat;
        logic        rs;
        logic        ri;
        logic [22:0] rf;

        rst          = 1'b1;
        valid_i      = 1'b0;
        ready_i      = 1'b1;
        sign_i       = 1'b0;
        integer_i    = 1'b0;
        fractional_i = 23'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_fp_o", fp_o, 32'h0);
        checkOutput("reset_valid_o", {31'd0, valid_o}, 32'd0);
        checkOutput("reset_ready_o", {31'd0, ready_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", {31'd0, ready_o}, 32'd1);
        @(posedge clk);
        #1;

        runVector("one",        1'b0, 1'b1, 23'h000000, 32'h3F800000);
        runVector("neg_1p5",    1'b1, 1'b1, 23'h400000, 32'hBFC00000);
        runVector("half",       1'b0, 1'b0, 23'h400000, 32'h3F000000);
        runVector("three_q",    1'b0, 1'b0, 23'h600000, 32'h3F400000);
        runVector("max",        1'b0, 1'b1, 23'h7FFFFF, 32'h3FFFFFFF);
        runVector("lsb_pos",    1'b0, 1'b0, 23'h000001, 32'h34000000);
        runVector("lsb_neg",    1'b1, 1'b0, 23'h000001, 32'hB4000000);
        runVector("zero_neg",   1'b1, 1'b0, 23'h000000, 32'h80000000);
        runVector("zero_pos",   1'b0, 1'b0, 23'h000000, 32'h00000000);

        for (int n = 1; n <= 23; n++) begin
            runVector($sformatf("bit_%0d", n), 1'b0, 1'b0, 23'(1) << (23 - n),
                      {1'b0, 8'(127 - n), 23'd0});
        end

        // Backpressure: result must hold while inputs churn and nothing new is captured.
        ready_i = 1'b0;
        applyStimulus(1'b0, 1'b1, 23'h123456);
        waitResult(fp, lat);
        checkOutput("bp_latency", lat, 32'd5);
        checkOutput("bp_fp", fp, refFp(1'b0, 1'b1, 23'h123456));
        held = fp;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            valid_i      = 1'($urandom);
            sign_i       = 1'($urandom);
            integer_i    = 1'($urandom);
            fractional_i = 23'($urandom);
            @(negedge clk);
            checkOutput("bp_fp_stable", fp_o, held);
            checkOutput("bp_valid_o", {31'd0, valid_o}, 32'd1);
            checkOutput("bp_ready_o", {31'd0, ready_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("bp_release_valid_o", {31'd0, valid_o}, 32'd0);
        checkOutput("bp_release_ready_o", {31'd0, ready_o}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_no_second", {31'd0, valid_o}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Reset during the third normalisation step abandons the conversion.
        applyStimulus(1'b1, 1'b0, 23'h00ABCD);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready_o", {31'd0, ready_o}, 32'd1);
        repeat (12) begin
            @(negedge clk);
            checkOutput("abort_valid_o", {31'd0, valid_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        runVector("after_abort", 1'b0, 1'b0, 23'h200000, 32'h3E800000);

        for (int r = 0; r < 150; r++) begin
            rs = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                ri = 1'b0;
                rf = 23'd0;
            end else begin
                ri = 1'($urandom);
                rf = 23'($urandom) >> $urandom_range(0, 22);
            end
            ready_i = 1'b0;
            applyStimulus(rs, ri, rf);
            waitResult(fp, lat);
            checkOutput("rand_latency", lat, 32'd5);
            checkOutput("rand_fp", fp, refFp(rs, ri, rf));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk);
            #1 ready_i = 1'b1;
            @(posedge clk);
            #1 ready_i = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
